// File: rtl/aes_kexp_seq_if.sv
// Handshake and round-key bus between the key source and the AES key expander.
// The expander drives busy/done/valid and the registered schedule words.
interface aes_kexp_seq_if #(parameter int Nk = 4);
  localparam int NW = 4 * (Nk + 7);

  logic              start;
  logic [32*Nk-1:0]  key;
  logic              busy;
  logic              done;
  logic              valid;
  logic [31:0]       Word [0:NW-1];

  modport master (output start, key, input busy, done, valid, Word);
  modport slave  (input start, key, output busy, done, valid, Word);
endinterface

// File: rtl/aes_kexp_seq.sv
// Iterative AES key expansion: one schedule word per clock through a single
// four-lookup S-box path; the full round-key array is held in registers.
module aes_kexp_seq #(
  parameter int Nk = 4
) (
  input  logic          clock,
  input  logic          reset,
  aes_kexp_seq_if.slave bus
);
  localparam int Nb = 4;
  localparam int Nr = Nk + 6;
  localparam int NW = Nb * (Nr + 1);
  localparam int IW = $clog2(NW);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [2:0]      kcnt_r;     // idx mod Nk, kept as a counter since Nk=6 is not a power of two
  logic [7:0]      rcon_r;
  logic            busy_r;
  logic            done_r;
  logic            valid_r;
  logic [31:0]     word_r [0:NW-1];

  logic [31:0]     prev_s;
  logic [31:0]     t_s;
  logic [31:0]     next_s;

  // Next schedule word from Word[idx-1] and Word[idx-Nk].
  always_comb begin
    prev_s = word_r[idx_r - IW'(1)];
    if (kcnt_r == 3'd0) begin
      t_s = sub_word(rot_word(prev_s)) ^ {rcon_r, 24'h000000};
    end else if ((Nk > 6) && (kcnt_r == 3'd4)) begin
      t_s = sub_word(prev_s);
    end else begin
      t_s = prev_s;
    end
    next_s = word_r[idx_r - IW'(Nk)] ^ t_s;
  end

  // Control FSM and schedule register file.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      kcnt_r  <= 3'd0;
      rcon_r  <= 8'h01;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        word_r[i] <= 32'h0;
      end
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            for (int j = 0; j < Nk; j++) begin
              word_r[j] <= bus.key[32*Nk-1-32*j -: 32];
            end
            idx_r   <= IW'(Nk);
            kcnt_r  <= 3'd0;
            rcon_r  <= 8'h01;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            state_r <= EXPAND;
          end else begin
            state_r <= IDLE;
          end
        end
        EXPAND: begin
          word_r[idx_r] <= next_s;
          if (kcnt_r == 3'd0) begin
            rcon_r <= xtime(rcon_r);
          end
          kcnt_r <= (kcnt_r == 3'(Nk - 1)) ? 3'd0 : kcnt_r + 3'd1;
          // idx parks on the last word rather than wrapping.
          if (idx_r == IW'(NW - 1)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            valid_r <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + IW'(1);
            state_r <= EXPAND;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.valid = valid_r;

  for (genvar g = 0; g < NW; g++) begin : g_word
    assign bus.Word[g] = word_r[g];
  end

endmodule

// File: tb/tb_aes_kexp_seq.sv
// Scoreboard bench for aes_kexp_seq at Nk=4/6/8; expected schedules come from an
// independent model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_kexp_seq;
  typedef logic [59:0][31:0] sched_t;
  typedef struct packed {
    logic [31:0] start_cyc;
    sched_t      w;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] sbox_t [0:255];
  exp_t q4 [$];
  exp_t q6 [$];
  exp_t q8 [$];

  aes_kexp_seq_if #(.Nk(4)) b4 ();
  aes_kexp_seq_if #(.Nk(6)) b6 ();
  aes_kexp_seq_if #(.Nk(8)) b8 ();

  aes_kexp_seq #(.Nk(4)) u4 (.clock(clock), .reset(reset), .bus(b4));
  aes_kexp_seq #(.Nk(6)) u6 (.clock(clock), .reset(reset), .bus(b6));
  aes_kexp_seq #(.Nk(8)) u8 (.clock(clock), .reset(reset), .bus(b8));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic sched_t ref_sched(input logic [255:0] k, input int nk);
    sched_t      w = '0;
    logic [31:0] t;
    logic [79:0] rcv = 80'h01020408102040801b36;
    int          nw = 4 * (nk + 7);
    for (int j = 0; j < nk; j++) w[j] = k[255-32*j -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcv[79-8*(i/nk-1) -: 8], 24'h000000};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  task automatic go(input int nk, input logic [255:0] k);
    exp_t e;
    e.start_cyc = 32'(cyc + 1);
    e.w = ref_sched(k, nk);
    case (nk)
      4: begin b4.key = k[255 -: 128]; b4.start = 1'b1; q4.push_back(e); end
      6: begin b6.key = k[255 -: 192]; b6.start = 1'b1; q6.push_back(e); end
      8: begin b8.key = k;             b8.start = 1'b1; q8.push_back(e); end
      default: ;
    endcase
    @(negedge clock);
    b4.start = 1'b0;
    b6.start = 1'b0;
    b8.start = 1'b0;
  endtask

  task automatic wait_done(input int nk, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      case (nk)
        4: got = b4.done;
        6: got = b6.done;
        8: got = b8.done;
        default: got = 1'b0;
      endcase
    end
    check_val(tag, {31'd0, got}, 32'd1);
  endtask

  // Scoreboard: each done pulse pops the oldest expected schedule.
  always @(negedge clock) begin
    exp_t e;
    if (b4.done === 1'b1) begin
      if (q4.size() == 0) check_val("unexp_done4", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check_val("lat4", 32'(cyc) - e.start_cyc, 32'd40);
        check_val("valid4", {31'd0, b4.valid}, 32'd1);
        check_val("busy4", {31'd0, b4.busy}, 32'd0);
        for (int i = 0; i < 44; i++) check_val($sformatf("w4[%0d]", i), b4.Word[i], e.w[i]);
      end
    end
    if (b6.done === 1'b1) begin
      if (q6.size() == 0) check_val("unexp_done6", 32'd1, 32'd0);
      else begin
        e = q6.pop_front();
        check_val("lat6", 32'(cyc) - e.start_cyc, 32'd46);
        check_val("valid6", {31'd0, b6.valid}, 32'd1);
        for (int i = 0; i < 52; i++) check_val($sformatf("w6[%0d]", i), b6.Word[i], e.w[i]);
      end
    end
    if (b8.done === 1'b1) begin
      if (q8.size() == 0) check_val("unexp_done8", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check_val("lat8", 32'(cyc) - e.start_cyc, 32'd52);
        check_val("valid8", {31'd0, b8.valid}, 32'd1);
        for (int i = 0; i < 60; i++) check_val($sformatf("w8[%0d]", i), b8.Word[i], e.w[i]);
      end
    end
  end

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KC1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [7:0]  inv;
    logic [31:0] acc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    b4.start = 1'b0; b6.start = 1'b0; b8.start = 1'b0;
    b4.key = '0; b6.key = '0; b8.key = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst_busy", {31'd0, b4.busy}, 32'd0);
    check_val("rst_done", {31'd0, b4.done}, 32'd0);
    check_val("rst_valid", {31'd0, b4.valid}, 32'd0);
    check_val("rst_w0", b4.Word[0], 32'h0);
    check_val("rst_w43", b4.Word[43], 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // T1: AES-128 reference vector
    go(4, {K1, 128'h0});
    check_val("t1_busy", {31'd0, b4.busy}, 32'd1);
    check_val("t1_valid_lo", {31'd0, b4.valid}, 32'd0);
    wait_done(4, "t1_done");
    check_val("t1_w4", b4.Word[4], 32'ha0fafe17);
    check_val("t1_w43", b4.Word[43], 32'hb6630ca6);
    @(negedge clock);
    check_val("t1_done_pulse", {31'd0, b4.done}, 32'd0);
    check_val("t1_valid_hold", {31'd0, b4.valid}, 32'd1);

    // T4: a second start mid-expansion with a different key must be ignored
    go(4, {K1, 128'h0});
    repeat (8) @(negedge clock);
    b4.key = KC1;
    b4.start = 1'b1;
    @(negedge clock);
    b4.start = 1'b0;
    wait_done(4, "t4_done");
    check_val("t4_w43", b4.Word[43], 32'hb6630ca6);
    repeat (3) @(negedge clock);

    // T5: reset in the middle of an expansion
    go(4, {K1, 128'h0});
    repeat (18) @(negedge clock);
    check_val("t5_busy_mid", {31'd0, b4.busy}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    q4.delete();
    acc = 32'h0;
    for (int i = 0; i < 44; i++) acc = acc | b4.Word[i];
    check_val("t5_busy", {31'd0, b4.busy}, 32'd0);
    check_val("t5_valid", {31'd0, b4.valid}, 32'd0);
    check_val("t5_words_zero", acc, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    go(4, {K1, 128'h0});
    wait_done(4, "t5_done");
    check_val("t5_w4", b4.Word[4], 32'ha0fafe17);

    // T6: restart on the done cycle with a new key
    go(4, {KC1, 128'h0});
    check_val("t6_busy", {31'd0, b4.busy}, 32'd1);
    check_val("t6_valid_drop", {31'd0, b4.valid}, 32'd0);
    check_val("t6_done_lo", {31'd0, b4.done}, 32'd0);
    repeat (20) @(negedge clock);
    check_val("t6_valid_mid", {31'd0, b4.valid}, 32'd0);
    wait_done(4, "t6_done");
    check_val("t6_w43", b4.Word[43], 32'h4d2b30c5);

    // T2: AES-192
    go(6, {K192, 64'h0});
    wait_done(6, "t2_done");
    check_val("t2_w6", b6.Word[6], 32'hfe0c91f7);
    check_val("t2_w51", b6.Word[51], 32'h01002202);

    // T3: AES-256, exercises the idx%Nk==4 SubWord
    go(8, K256);
    wait_done(8, "t3_done");
    check_val("t3_w8", b8.Word[8], 32'h9ba35411);
    check_val("t3_w59", b8.Word[59], 32'h706c631e);
    check_val("t3_w12", b8.Word[12], 32'ha8b09c1a);

    repeat (3) @(negedge clock);
    check_val("q_empty", 32'(q4.size() + q6.size() + q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
